gray_ptr_tracker: RTL and testbench
===================================

Name: gray_ptr_tracker

Overview:
- Registered FIFO-pointer unit for one side (writer or reader) of a dual-pointer FIFO.
- Keeps a binary pointer with a wrap bit and advances it on a valid/ready handshake.
- Publishes a registered Gray-coded copy of the pointer (binary-to-Gray encode), so the peer side can safely synchronize it.
- Decodes the peer's already-synchronized Gray pointer back to binary with a hi-to-lo XOR prefix scan, and derives full/empty, occupancy and an overflow error.

Parameters:
- ptr_width_p, 4, address bits; FIFO depth = 2^ptr_width_p; pointers are ptr_width_p+1 bits wide.
- is_writer_p, 1, 1 = write side (tracks full); 0 = read side (tracks empty).

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- v_i  in  1  request to advance the pointer (push if writer, pop if reader).
- ready_o  out  1  advance permitted: writer = !full, reader = !empty.
- peer_gray_i  in  ptr_width_p+1  peer pointer, Gray coded, already synchronized into clk_i.
- ptr_bin_o  out  ptr_width_p  RAM address = low bits of the binary pointer.
- ptr_gray_o  out  ptr_width_p+1  registered Gray pointer, sent to the peer.
- count_o  out  ptr_width_p+1  occupancy as seen from this side, 0..2^ptr_width_p.
- overflow_o  out  1  sticky error: decoded occupancy exceeded the depth.

Behaviour:
- Reset (async assert, sync deassert by the caller): bin_r=0, gray_r=0, overflow_r=0.
  - Resulting outputs: ptr_bin_o=0, ptr_gray_o=0.
  - Writer with peer_gray_i=0: ready_o=1, count_o=0.
  - Reader with peer_gray_i=0: ready_o=0, count_o=0.
- Handshake: fire = v_i & ready_o.
  - On fire at a clock edge: bin_r <= bin_r+1, and gray_r <= next ^ (next>>1), using the same next value.
  - Latency 1 cycle; gray_r changes exactly one bit per fire.
  - v_i while ready_o=0 is ignored; no state change and no error.
- Wrap: bin_r rolls from 2^(ptr_width_p+1)-1 to 0 and gray_r wraps to 0 with it.
- Peer decode is combinational: peer_bin[k] = XOR of peer_gray_i[top:k] (hi-to-lo prefix XOR); peer_bin[top] = peer_gray_i[top].
- Full (writer): gray_r == {~peer_gray_i[top:top-1], peer_gray_i[top-2:0]}.
- Empty (reader): gray_r == peer_gray_i.
- ready_o is combinational from registered state and peer_gray_i only. It has no dependence on v_i.
- count_o is computed modulo 2^(ptr_width_p+1):
  - writer: bin_r - peer_bin;
  - reader: peer_bin - bin_r.
- overflow_r sets when count_o > 2^ptr_width_p (inconsistent peer pointer) and holds until reset.
  - Setting overflow_r does not block the handshake.
- Simultaneous events:
  - A peer change in the same cycle as a fire is fine; ready_o for the next cycle uses the new values of both.
  - The pessimism from synchronizer lag is accepted and never corrupts state.
- Reset mid-operation: all state clears immediately on reset_n_i falling, regardless of clk_i.

Decomposition:
- Shared package holds two functions:
  - bin2gray(width) function;
  - ptr_full/ptr_empty compare helper.
- One sub-module: gray_to_bin (parameter width_p).
  - Combinational hi-to-lo XOR prefix scan, log2 stages of shift-and-XOR.
  - Reused by the peer pointer decoder.

Test Plan:
- Writer, ptr_width_p=4, peer_gray_i=0, v_i=1 for 17 cycles -> 16 fires.
  - After the 16th: ptr_gray_o=5'b11000, count_o=16, ready_o=0.
  - The 17th request is ignored.
  - overflow_o=0.
- Writer full, then peer_gray_i set to 5'b00001 (peer_bin=1) -> ready_o=1 and count_o=15 in the same cycle; one fire -> full again.
- Wrap: drive 32 fires with the peer tracking 1 behind.
  - At bin 31, ptr_gray_o=5'b10000; next fire gives ptr_gray_o=0.
  - Every transition is a single-bit Gray change (checked by assertion).
- Reader, peer_gray_i=0 -> ready_o=0.
  - Set peer_gray_i=5'b00011 (bin 2): count_o=2.
  - Two fires: ptr_bin_o goes 1 then 2, and ready_o=0 after the second.
- Overflow: writer at bin 0, peer_gray_i=5'b01101 (bin 9).
  - count_o = 0-9 mod 32 = 23 > 16, so overflow_o=1 next edge.
  - Stays 1 after the peer is restored; clears only on reset_n_i=0.
- Reset mid-stream: assert reset_n_i between clock edges after 5 fires.
  - Immediately: ptr_bin_o=0, ptr_gray_o=0, overflow_o=0.
  - Pointer restarts at 1 on the first fire after deassert.

Source files
------------

// File: rtl/gray_ptr_tracker_pkg.sv
// Shared helpers for the Gray-coded FIFO pointer tracker: encoding and the
// full/empty comparisons, written on a word-wide container and narrowed by the caller.
package gray_ptr_tracker_pkg;

   localparam int word_w_c = 32;

   typedef logic [word_w_c-1:0] ptr_word_t;

   function automatic ptr_word_t bin2gray(input ptr_word_t bin);
      return bin ^ (bin >> 1);
   endfunction

   // Full means the pointers differ by exactly one depth: top two Gray bits inverted.
   function automatic logic ptr_full(input ptr_word_t gray, input ptr_word_t peer,
                                     input int width);
      ptr_word_t flip;
      flip = ptr_word_t'(32'd3) << (width - 32'sd2);
      return gray == (peer ^ flip);
   endfunction

   function automatic logic ptr_empty(input ptr_word_t gray, input ptr_word_t peer);
      return gray == peer;
   endfunction

endpackage

// File: rtl/gray_ptr_tracker_if.sv
// Handshake and pointer bundle between a pointer tracker and its user.
interface gray_ptr_tracker_if #(
   parameter int ptr_width_p = 4
) ();

   logic                   v_i;
   logic                   ready_o;
   logic [ptr_width_p:0]   peer_gray_i;
   logic [ptr_width_p-1:0] ptr_bin_o;
   logic [ptr_width_p:0]   ptr_gray_o;
   logic [ptr_width_p:0]   count_o;
   logic                   overflow_o;

   modport master (
      output v_i, peer_gray_i,
      input  ready_o, ptr_bin_o, ptr_gray_o, count_o, overflow_o
   );

   modport slave (
      input  v_i, peer_gray_i,
      output ready_o, ptr_bin_o, ptr_gray_o, count_o, overflow_o
   );

endinterface

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary decoder: hi-to-lo prefix XOR built from
// log2(width) shift-and-XOR stages.
module gray_to_bin #(
   parameter int width_p = 5
) (
   input  logic [width_p-1:0] gray,
   output logic [width_p-1:0] bin
);

   localparam int stages_c = $clog2(width_p);

   logic [width_p-1:0] stage_s [stages_c+1];

   assign stage_s[0] = gray;

   for (genvar i = 0; i < stages_c; i++) begin : g_stage
      assign stage_s[i+1] = stage_s[i] ^ (stage_s[i] >> (32'sd1 << i));
   end

   assign bin = stage_s[stages_c];

endmodule

// File: rtl/gray_ptr_tracker.sv
// One side of a dual-pointer FIFO: binary pointer with wrap bit, registered
// Gray copy for the peer, and full/empty/occupancy derived from the peer pointer.
module gray_ptr_tracker
   import gray_ptr_tracker_pkg::*;
#(
   parameter int ptr_width_p = 4,
   parameter bit is_writer_p = 1'b1
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   gray_ptr_tracker_if.slave  bus
);

   localparam int pw_c = ptr_width_p + 1;

   typedef logic [ptr_width_p:0] ptr_t;

   localparam ptr_t one_c   = ptr_t'(1'b1);
   localparam ptr_t depth_c = {1'b1, {ptr_width_p{1'b0}}};

   ptr_t bin_r;
   ptr_t gray_r;
   logic overflow_r;

   ptr_t next_s;
   ptr_t gray_next_s;
   ptr_t peer_bin_s;
   ptr_t count_s;
   logic ready_s;
   logic fire_s;

   gray_to_bin #(.width_p(pw_c)) u_peer_dec (
      .gray (bus.peer_gray_i),
      .bin  (peer_bin_s)
   );

   // Next pointer, flow control and occupancy from registered state and the peer pointer.
   always_comb begin
      next_s      = bin_r + one_c;
      gray_next_s = ptr_t'(bin2gray(ptr_word_t'(next_s)));
      ready_s     = 1'b0;
      count_s     = '0;
      if (is_writer_p) begin
         ready_s = !ptr_full(ptr_word_t'(gray_r), ptr_word_t'(bus.peer_gray_i), pw_c);
         count_s = bin_r - peer_bin_s;
      end else begin
         ready_s = !ptr_empty(ptr_word_t'(gray_r), ptr_word_t'(bus.peer_gray_i));
         count_s = peer_bin_s - bin_r;
      end
      fire_s = bus.v_i & ready_s;
   end

   // Pointer state; overflow is sticky and never blocks the handshake.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         bin_r      <= '0;
         gray_r     <= '0;
         overflow_r <= 1'b0;
      end else begin
         if (fire_s) begin
            bin_r  <= next_s;
            gray_r <= gray_next_s;
         end
         overflow_r <= overflow_r | (count_s > depth_c);
      end
   end

   assign bus.ready_o    = ready_s;
   assign bus.ptr_bin_o  = bin_r[ptr_width_p-1:0];
   assign bus.ptr_gray_o = gray_r;
   assign bus.count_o    = count_s;
   assign bus.overflow_o = overflow_r;

endmodule

// File: tb/tb_gray_ptr_tracker.sv
// Self-checking bench: a writer and a reader tracker against an integer pointer model.
module tb_gray_ptr_tracker;

   logic clk;
   logic reset_n;

   int cmp_cnt = 0;
   int mis_cnt = 0;

   // Model: pointers as plain integers modulo 32, peers held as integers too.
   int w_ptr, w_peer, r_ptr, r_peer;
   bit w_ovf, r_ovf;

   gray_ptr_tracker_if #(.ptr_width_p(4)) wif ();
   gray_ptr_tracker_if #(.ptr_width_p(4)) rif ();

   gray_ptr_tracker #(.ptr_width_p(4), .is_writer_p(1'b1)) u_wr (
      .clk_i(clk), .reset_n_i(reset_n), .bus(wif.slave));
   gray_ptr_tracker #(.ptr_width_p(4), .is_writer_p(1'b0)) u_rd (
      .clk_i(clk), .reset_n_i(reset_n), .bus(rif.slave));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int mgray(input int b);
      return (b ^ (b >> 1)) & 31;
   endfunction

   function automatic int wcount();
      return (w_ptr - w_peer) & 31;
   endfunction

   function automatic int rcount();
      return (r_peer - r_ptr) & 31;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      cmp_cnt++;
      assert (obs === exp) else begin
         mis_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      #1;
      chk({tag, "_wbin"},   32'(wif.ptr_bin_o),  32'(w_ptr & 15));
      chk({tag, "_wgray"},  32'(wif.ptr_gray_o), 32'(mgray(w_ptr)));
      chk({tag, "_wcount"}, 32'(wif.count_o),    32'(wcount()));
      chk({tag, "_wready"}, 32'(wif.ready_o),    32'(wcount() != 16));
      chk({tag, "_wovf"},   32'(wif.overflow_o), 32'(w_ovf));
      chk({tag, "_rbin"},   32'(rif.ptr_bin_o),  32'(r_ptr & 15));
      chk({tag, "_rgray"},  32'(rif.ptr_gray_o), 32'(mgray(r_ptr)));
      chk({tag, "_rcount"}, 32'(rif.count_o),    32'(rcount()));
      chk({tag, "_rready"}, 32'(rif.ready_o),    32'(rcount() != 0));
      chk({tag, "_rovf"},   32'(rif.overflow_o), 32'(r_ovf));
   endtask

   task automatic set_wpeer(input int b);
      w_peer = b & 31;
      wif.peer_gray_i = 5'(mgray(w_peer));
   endtask

   task automatic set_rpeer(input int b);
      r_peer = b & 31;
      rif.peer_gray_i = 5'(mgray(r_peer));
   endtask

   // One clock edge: model decides fires and overflow from pre-edge values.
   task automatic cyc();
      bit fw, fr, nw_ovf, nr_ovf;
      logic [4:0] pg_w, pg_r;
      fw     = wif.v_i && (wcount() != 16);
      fr     = rif.v_i && (rcount() != 0);
      nw_ovf = w_ovf || (wcount() > 16);
      nr_ovf = r_ovf || (rcount() > 16);
      pg_w   = wif.ptr_gray_o;
      pg_r   = rif.ptr_gray_o;
      @(posedge clk);
      #1;
      if (fw) w_ptr = (w_ptr + 1) & 31;
      if (fr) r_ptr = (r_ptr + 1) & 31;
      w_ovf = nw_ovf;
      r_ovf = nr_ovf;
      if (fw) chk("w_gray_1bit", 32'($countones(pg_w ^ wif.ptr_gray_o)), 32'd1);
      if (fr) chk("r_gray_1bit", 32'($countones(pg_r ^ rif.ptr_gray_o)), 32'd1);
   endtask

   task automatic hard_reset();
      reset_n = 1'b0;
      #1;
      w_ptr = 0; r_ptr = 0; w_ovf = 1'b0; r_ovf = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b1;
      wif.v_i = 1'b0;
      rif.v_i = 1'b0;
      set_wpeer(0);
      set_rpeer(0);
      #1;
      hard_reset();
      check_all("reset");

      // Fill the writer: 17 requests, 16 accepted.
      wif.v_i = 1'b1;
      for (int i = 0; i < 17; i++) begin
         cyc();
         check_all("fill");
      end
      wif.v_i = 1'b0;
      chk("w_full_gray",  32'(wif.ptr_gray_o), 32'h18);
      chk("w_full_count", 32'(wif.count_o),    32'd16);
      chk("w_full_ready", 32'(wif.ready_o),    32'd0);

      // Peer advances by one: room for exactly one more write.
      set_wpeer(1);
      check_all("peer1");
      chk("w_peer1_count", 32'(wif.count_o), 32'd15);
      wif.v_i = 1'b1;
      cyc();
      check_all("refill");
      chk("w_refill_ready", 32'(wif.ready_o), 32'd0);

      // Wrap: 32 fires with the peer one behind.
      for (int i = 0; i < 32; i++) begin
         set_wpeer(w_ptr);
         cyc();
         check_all("wrap");
         if (w_ptr == 31) chk("w_gray31", 32'(wif.ptr_gray_o), 32'h10);
         if (w_ptr == 0)  chk("w_gray_wrap0", 32'(wif.ptr_gray_o), 32'h0);
      end

      // Random consistent peers and requests on both sides.
      for (int i = 0; i < 300; i++) begin
         set_wpeer(w_ptr - int'($urandom_range(0, 16)));
         set_rpeer(r_ptr + int'($urandom_range(0, 16)));
         wif.v_i = 1'($urandom_range(0, 1));
         rif.v_i = 1'($urandom_range(0, 1));
         cyc();
         check_all("rand");
      end

      // Reader directed.
      wif.v_i = 1'b0;
      rif.v_i = 1'b0;
      set_wpeer(0);
      set_rpeer(0);
      hard_reset();
      check_all("rd_empty");
      set_rpeer(2);
      check_all("rd_peer2");
      chk("r_count2", 32'(rif.count_o), 32'd2);
      rif.v_i = 1'b1;
      cyc();
      check_all("rd_pop1");
      chk("r_bin1", 32'(rif.ptr_bin_o), 32'd1);
      cyc();
      check_all("rd_pop2");
      chk("r_bin2",   32'(rif.ptr_bin_o), 32'd2);
      chk("r_ready0", 32'(rif.ready_o),   32'd0);
      rif.v_i = 1'b0;

      // Overflow on an inconsistent peer; sticky until reset.
      hard_reset();
      set_wpeer(9);
      check_all("ovf_pre");
      chk("w_ovf_count23", 32'(wif.count_o), 32'd23);
      cyc();
      check_all("ovf_set");
      chk("w_ovf_set", 32'(wif.overflow_o), 32'd1);
      set_wpeer(0);
      cyc();
      check_all("ovf_hold");
      chk("w_ovf_hold", 32'(wif.overflow_o), 32'd1);

      // Five fires, then reset between clock edges.
      wif.v_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         check_all("pre_rst");
      end
      reset_n = 1'b0;
      #1;
      chk("rst_bin",  32'(wif.ptr_bin_o),  32'd0);
      chk("rst_gray", 32'(wif.ptr_gray_o), 32'd0);
      chk("rst_ovf",  32'(wif.overflow_o), 32'd0);
      w_ptr = 0; r_ptr = 0; w_ovf = 1'b0; r_ovf = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      cyc();
      check_all("post_rst");
      chk("w_restart_bin1", 32'(wif.ptr_bin_o), 32'd1);
      wif.v_i = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
      $finish;
   end

endmodule
